tdes_seq: RTL and testbench
===========================

TDES_SEQ -- requirements
Module: tdes_seq

Interface
REQ-001 The block SHALL have parameter DES_LAT, default 16, giving the DES core latency in clk cycles (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  request present.
REQ-005 The block SHALL have port in_ready  output  1  request accepted when high with in_valid.
REQ-006 The block SHALL have port in_data  input  64  plaintext or ciphertext block.
REQ-007 The block SHALL have ports in_key1, in_key2, in_key3  input  56 each  parity-stripped keys.
REQ-008 The block SHALL have port in_decrypt  input  1  1 = decrypt, 0 = encrypt.
REQ-009 The block SHALL have port in_triple  input  1  1 = 3DES EDE (three passes), 0 = single DES (one pass, in_key1).
REQ-010 The block SHALL have port out_valid  output  1  result present.
REQ-011 The block SHALL have port out_ready  input  1  result consumed when high with out_valid.
REQ-012 The block SHALL have port out_data  output  64  result block.
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 The block SHALL have ports core_in (output, 64), core_key (output, 56) and core_decrypt (output, 1), all registered drives of the shared des core.
REQ-015 The block SHALL have port core_out  input  64  des core result.

Function
REQ-016 States SHALL be IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 An accept SHALL occur on the rising edge at which in_valid && in_ready; it SHALL latch in_data, the keys, in_decrypt and in_triple; later changes to these inputs SHALL have no effect until the next accept.
REQ-018 On accept, the block SHALL enter RUN with pass=0 and cnt=0, and SHALL load core_in, core_key and core_decrypt for pass 0 on that edge.
REQ-019 In RUN, cnt SHALL increment each cycle; core_in, core_key and core_decrypt SHALL hold stable for the whole pass.
REQ-020 On the edge where cnt==DES_LAT-1, the block SHALL capture core_out into the data register.
REQ-021 At that edge, if passes remain, the block SHALL set pass+1 and cnt=0, and core_in SHALL take the captured value.
REQ-022 At that edge, if no passes remain, the block SHALL enter DONE.
REQ-023 Pass schedule, single: K1 with in_decrypt.
REQ-024 Pass schedule, triple encrypt: K1 encrypt, then K2 decrypt, then K3 encrypt.
REQ-025 Pass schedule, triple decrypt: K3 decrypt, then K2 encrypt, then K1 decrypt.
REQ-026 Latency from the accept edge to out_valid high SHALL be DES_LAT cycles (single) or 3*DES_LAT cycles (triple).
REQ-027 In DONE, out_data SHALL hold stable while out_ready is low.
REQ-028 On the edge with out_valid && out_ready, the block SHALL return to IDLE; the earliest next accept SHALL be the following edge, so there is no simultaneous accept-and-deliver.
REQ-029 cnt SHALL be 8 bits and pass SHALL be 2 bits; neither SHALL wrap, since the transitions above bound them.
REQ-030 out_data SHALL equal the data register; core_in, core_key and core_decrypt SHALL keep their last values in IDLE and DONE.

Reset
REQ-031 While rst is high, the block SHALL be in IDLE with in_ready=1, out_valid=0, busy=0, out_data=0, core_in=0, core_key=0, core_decrypt=0, cnt=0 and pass=0.
REQ-032 A rst asserted mid-RUN or in DONE SHALL abort the operation immediately, with no output delivered; the first accept SHALL be possible on the first edge after rst is deasserted.

Verification
REQ-033 The bench SHALL cover single DES encrypt, using a behavioural DES model with DES_LAT=16: key 56'h... from 64'h10316E028C8F3B4A parity-stripped, in_data 0 -> out_valid at accept+16 with out_data=64'h82DCBAFBDEAB6602.
REQ-034 The bench SHALL cover single DES decrypt: same key, in_data 64'h82DCBAFBDEAB6602 -> out_data=0.
REQ-035 The bench SHALL cover triple with K1=K2=K3 equal to that key, in_data 0, encrypt -> out_data=64'h82DCBAFBDEAB6602 at accept+48, with the core_key/core_decrypt sequence K1/0, K2/1, K3/0 checked at each pass start.
REQ-036 The bench SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-037 The bench SHALL cover reset mid-operation: rst pulsed at accept+7 of a triple op -> out_valid never rises for that op; a following single op returns the correct result.
REQ-038 The bench SHALL cover input isolation: in_data and keys changed each cycle during RUN -> result matches the values latched at accept.

Source files
------------

// File: rtl/tdes_seq_if.sv
// Request/response handshake bundle for the TDES sequencer.
// The master drives requests and consumes results; the slave is the sequencer.
interface tdes_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [55:0] in_key1;
    logic [55:0] in_key2;
    logic [55:0] in_key3;
    logic        in_decrypt;
    logic        in_triple;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (
        output in_valid, in_data, in_key1, in_key2, in_key3, in_decrypt, in_triple, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key1, in_key2, in_key3, in_decrypt, in_triple, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/tdes_seq.sv
// Single/triple DES sequencer around one shared, fixed-latency DES core.
// A request is latched on accept, then run as one pass (single DES) or three
// EDE passes (3DES). Each pass holds the core inputs stable for DES_LAT cycles
// and captures the core result on the last cycle of the pass.
module tdes_seq #(
    parameter int DES_LAT = 16
) (
    input  logic        clk,
    input  logic        rst,
    tdes_seq_if.slave   bus,
    output logic        busy,
    output logic [63:0] core_in,
    output logic [55:0] core_key,
    output logic        core_decrypt,
    input  logic [63:0] core_out
);

    localparam logic [7:0] LAST_CNT = 8'(DES_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [1:0]  pass_q;
    logic [63:0] data_q;
    logic [55:0] k1_q, k2_q, k3_q;
    logic        dec_q;
    logic        trip_q;

    logic        ready;
    logic        valid;
    logic        accept;
    logic        pass_end;
    logic        last_pass;

    // Key used by pass p. Triple encrypt walks K1,K2,K3; triple decrypt walks
    // K3,K2,K1; single DES always uses K1.
    function automatic logic [55:0] pass_key(input logic [1:0]  p,
                                             input logic        trip,
                                             input logic        dec,
                                             input logic [55:0] k1,
                                             input logic [55:0] k2,
                                             input logic [55:0] k3);
        logic [55:0] k;
        k = k1;
        if (trip) begin
            case (p)
                2'd0:    k = dec ? k3 : k1;
                2'd1:    k = k2;
                default: k = dec ? k1 : k3;
            endcase
        end
        return k;
    endfunction

    // Direction of pass p. EDE flips the direction only on the middle pass.
    function automatic logic pass_dec(input logic [1:0] p,
                                      input logic       trip,
                                      input logic       dec);
        return (trip && p == 2'd1) ? ~dec : dec;
    endfunction

    assign accept    = (state_q == IDLE) && bus.in_valid;
    assign pass_end  = (state_q == RUN) && (cnt_q == LAST_CNT);
    assign last_pass = !trip_q || (pass_q == 2'd2);

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_data  = data_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs; in_ready only in IDLE, out_valid only in DONE.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        valid   = 1'b0;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                if (pass_end && last_pass) state_d = DONE;
            end
            DONE: begin
                valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, pass/cycle counters, result capture and core drive.
    // Core drives are only rewritten at accept and at pass boundaries, so they
    // stay put through each pass and keep their last values in IDLE/DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 8'd0;
            pass_q       <= 2'd0;
            data_q       <= 64'd0;
            k1_q         <= 56'd0;
            k2_q         <= 56'd0;
            k3_q         <= 56'd0;
            dec_q        <= 1'b0;
            trip_q       <= 1'b0;
            core_in      <= 64'd0;
            core_key     <= 56'd0;
            core_decrypt <= 1'b0;
        end else if (accept) begin
            k1_q         <= bus.in_key1;
            k2_q         <= bus.in_key2;
            k3_q         <= bus.in_key3;
            dec_q        <= bus.in_decrypt;
            trip_q       <= bus.in_triple;
            cnt_q        <= 8'd0;
            pass_q       <= 2'd0;
            core_in      <= bus.in_data;
            core_key     <= pass_key(2'd0, bus.in_triple, bus.in_decrypt,
                                     bus.in_key1, bus.in_key2, bus.in_key3);
            core_decrypt <= pass_dec(2'd0, bus.in_triple, bus.in_decrypt);
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 8'd1;
            if (pass_end) begin
                data_q <= core_out;
                if (!last_pass) begin
                    pass_q       <= pass_q + 2'd1;
                    cnt_q        <= 8'd0;
                    core_in      <= core_out;
                    core_key     <= pass_key(pass_q + 2'd1, trip_q, dec_q, k1_q, k2_q, k3_q);
                    core_decrypt <= pass_dec(pass_q + 2'd1, trip_q, dec_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_tdes_seq.sv
// Self-checking bench for tdes_seq: a behavioural DES core with DES_LAT latency
// sits on the core port; results are checked against a plain DES/3DES model.
module tb_tdes_seq;
    localparam int DES_LAT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [63:0] core_in;
    logic [55:0] core_key;
    logic        core_decrypt;
    logic [63:0] core_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdes_seq_if bus ();

    tdes_seq #(.DES_LAT(DES_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .core_in      (core_in),
        .core_key     (core_key),
        .core_decrypt (core_decrypt),
        .core_out     (core_out)
    );

    // ---------------- DES tables ----------------
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2,
                                  59,51,43,35,27,19,11,3, 60,52,44,36,63,55,47,39,
                                  31,23,15,7,62,54,46,38, 30,22,14,6,61,53,45,37,
                                  29,21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28, 15,6,21,10,23,19,12,4,
                                  26,8,16,7,27,20,13,2, 41,52,31,37,47,55,30,40,
                                  51,45,33,48,44,49,39,56, 34,53,46,42,50,36,29,32};
    localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SBOX [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    // Drop the parity bit (LSB) of each key byte.
    function automatic logic [55:0] strip(input logic [63:0] k);
        logic [55:0] r;
        for (int b = 0; b < 8; b++) r[55-7*b -: 7] = k[63-8*b -: 7];
        return r;
    endfunction

    // Plain DES on a parity-stripped key; tables are 1-based from the MSB.
    function automatic logic [63:0] des(input logic [63:0] blk, input logic [55:0] key, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] sk [16];
        logic [63:0] ip, pre, res;
        logic [31:0] l, r, f, s, t;
        logic [47:0] e, x;
        logic [5:0]  six;
        int          j, idx;
        for (int i = 1; i <= 56; i++) begin
            j = PC1_T[i-1];
            cd[56-i] = key[56-(j - j/8)];
        end
        c = cd[55:28];
        d = cd[27:0];
        for (int rd = 0; rd < 16; rd++) begin
            for (int n = 0; n < SH_T[rd]; n++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 1; i <= 48; i++) sk[rd][48-i] = cd[56-PC2_T[i-1]];
        end
        for (int i = 1; i <= 64; i++) ip[64-i] = blk[64-IP_T[i-1]];
        l = ip[63:32];
        r = ip[31:0];
        for (int rd = 0; rd < 16; rd++) begin
            for (int i = 1; i <= 48; i++) e[48-i] = r[32-E_T[i-1]];
            x = e ^ (dec ? sk[15-rd] : sk[rd]);
            for (int b = 0; b < 8; b++) begin
                six = x[47-6*b -: 6];
                idx = b*64 + int'({six[5], six[0]})*16 + int'(six[4:1]);
                s[31-4*b -: 4] = 4'(SBOX[idx]);
            end
            for (int i = 1; i <= 32; i++) f[32-i] = s[32-P_T[i-1]];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 1; i <= 64; i++) res[64-i] = pre[64-FP_T[i-1]];
        return res;
    endfunction

    // Whole-operation reference: single DES or 3DES EDE.
    function automatic logic [63:0] ref_tdes(input logic [63:0] dt, input logic [55:0] k1, k2, k3,
                                             input logic dec, input logic trip);
        if (!trip) return des(dt, k1, dec);
        if (!dec)  return des(des(des(dt, k1, 1'b0), k2, 1'b1), k3, 1'b0);
        return des(des(des(dt, k3, 1'b1), k2, 1'b0), k1, 1'b1);
    endfunction

    function automatic logic [55:0] rk();
        return 56'({$urandom(), $urandom()});
    endfunction

    // Behavioural core: result only becomes correct DES_LAT cycles after its
    // inputs last changed; before that it presents a wrong value.
    logic [120:0] core_last;
    int           core_age = 0;
    always @(negedge clk) begin
        logic [63:0] v;
        if ({core_in, core_key, core_decrypt} !== core_last) begin
            core_last = {core_in, core_key, core_decrypt};
            core_age  = 1;
        end else begin
            core_age++;
        end
        v = des(core_in, core_key, core_decrypt);
        core_out = (core_age >= DES_LAT) ? v : ~v;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        bus.in_data    = {$urandom(), $urandom()};
        bus.in_key1    = rk();
        bus.in_key2    = rk();
        bus.in_key3    = rk();
        bus.in_decrypt = 1'($urandom_range(0, 1));
        bus.in_triple  = 1'($urandom_range(0, 1));
    endtask

    // One full operation, entered and left at a negedge.
    task automatic run_op(input logic [63:0] dt, input logic [55:0] k1, k2, k3,
                          input logic dec, input logic trip, input bit scram, input int hold,
                          input logic [63:0] kat, input bit use_kat);
        int          n;
        logic [63:0] want;
        logic [63:0] mid [3];
        logic [55:0] ek [3];
        logic        ed [3];
        n    = trip ? 3*DES_LAT : DES_LAT;
        want = use_kat ? kat : ref_tdes(dt, k1, k2, k3, dec, trip);
        if (!trip)     begin ek = '{k1, k1, k1}; ed = '{dec, dec, dec}; end
        else if (!dec) begin ek = '{k1, k2, k3}; ed = '{1'b0, 1'b1, 1'b0}; end
        else           begin ek = '{k3, k2, k1}; ed = '{1'b1, 1'b0, 1'b1}; end
        mid[0] = dt;
        mid[1] = des(mid[0], ek[0], ed[0]);
        mid[2] = des(mid[1], ek[1], ed[1]);

        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1; bus.in_data = dt;
        bus.in_key1 = k1; bus.in_key2 = k2; bus.in_key3 = k3;
        bus.in_decrypt = dec; bus.in_triple = trip;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) @(negedge clk);
            if (scram) scramble_inputs();
            chk("out_valid_lat", 64'(bus.out_valid), 64'(k == n));
            if (k < n && k % DES_LAT == 0) begin
                chk("core_in_pass",  core_in, mid[k/DES_LAT]);
                chk("core_key_pass", 64'(core_key), 64'(ek[k/DES_LAT]));
                chk("core_dec_pass", 64'(core_decrypt), 64'(ed[k/DES_LAT]));
            end
        end
        chk("out_data", bus.out_data, want);
        // Offer a new request while DONE; it must not be taken.
        bus.in_valid = 1'b1;
        scramble_inputs();
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_data",  bus.out_data, want);
            chk("bp_in_ready",  64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("deliver_out_valid", 64'(bus.out_valid), 64'd0);
        chk("deliver_in_ready",  64'(bus.in_ready), 64'd1);
        chk("deliver_busy",      64'(busy), 64'd0);
        chk("idle_out_data",     bus.out_data, want);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_busy"},      64'(busy), 64'd0);
        chk({tag, "_out_data"},  bus.out_data, 64'd0);
        chk({tag, "_core_in"},   core_in, 64'd0);
        chk({tag, "_core_key"},  64'(core_key), 64'd0);
        chk({tag, "_core_dec"},  64'(core_decrypt), 64'd0);
    endtask

    initial begin
        logic [55:0] key;
        logic [55:0] a1, a2, a3;
        logic [63:0] ad;
        int          seen;
        key = strip(64'h10316E028C8F3B4A);
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0;
        bus.in_key1 = '0; bus.in_key2 = '0; bus.in_key3 = '0;
        bus.in_decrypt = 1'b0; bus.in_triple = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        chk_reset_state("rst");
        rst = 1'b0;

        // First accept on the first edge after reset release; known-answer tests.
        run_op(64'h0, key, key, key, 1'b0, 1'b0, 0, 0, 64'h82DCBAFBDEAB6602, 1);
        run_op(64'h82DCBAFBDEAB6602, key, key, key, 1'b1, 1'b0, 0, 0, 64'h0, 1);
        run_op(64'h0, key, key, key, 1'b0, 1'b1, 0, 0, 64'h82DCBAFBDEAB6602, 1);

        // Backpressure: result held for 10 cycles.
        run_op({$urandom(), $urandom()}, rk(), rk(), rk(), 1'b0, 1'b0, 0, 10, 64'h0, 0);

        // Reset in the middle of a triple operation.
        a1 = rk(); a2 = rk(); a3 = rk(); ad = {$urandom(), $urandom()};
        bus.in_valid = 1'b1; bus.in_data = ad;
        bus.in_key1 = a1; bus.in_key2 = a2; bus.in_key3 = a3;
        bus.in_decrypt = 1'b0; bus.in_triple = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_state("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 3*DES_LAT + 4; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        chk("aborted_op_silent", 64'(seen), 64'd0);
        run_op(64'h0, key, key, key, 1'b0, 1'b0, 0, 0, 64'h82DCBAFBDEAB6602, 1);

        // Input isolation: request inputs churn every cycle while running.
        run_op({$urandom(), $urandom()}, rk(), rk(), rk(), 1'b1, 1'b1, 1, 2, 64'h0, 0);
        run_op({$urandom(), $urandom()}, rk(), rk(), rk(), 1'b0, 1'b0, 1, 0, 64'h0, 0);

        // Random mix of modes, scrambling and backpressure.
        for (int i = 0; i < 6; i++) begin
            run_op({$urandom(), $urandom()}, rk(), rk(), rk(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 64'h0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
